// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parallel RGB LCD timing (pixel strobe, DE/HSYNC/VSYNC, x/y publish, registered colour).
// Define LCD_TEST_PATTERN_EN to replace the user colour with eight vertical colour bars.
module lcd_timing_gen #(
  parameter int CLK_DIV  = 3,
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] red_in,
  input  logic [5:0] green_in,
  input  logic [4:0] blue_in,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       pixel_en,
  output logic       frame_start,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_red,
  output logic [5:0] lcd_green,
  output logic [4:0] lcd_blue
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SB = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SB = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  logic [DW-1:0] div;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic h_act, v_act, vis, h_sync, v_sync, h_last, v_last;
  logic [4:0] r_src;
  logic [5:0] g_src;
  logic [4:0] b_src;
  always_comb begin
    h_act = hc < H_ACT;
    v_act = vc < V_ACT;
    vis = h_act && v_act;
    h_sync = hc >= H_SB && hc <= H_SE;
    v_sync = vc >= V_SB && vc <= V_SE;
    h_last = hc == H_LAST;
    v_last = vc == V_LAST;
    x = h_act ? 9'(hc) : '0;
    y = v_act ? 9'(vc) : '0;
    frame_start = pixel_en && h_last && v_last;
  end
`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar = 3'((32'(hc) * 8) / H_ACTIVE);
    r_src = {5{bar[2]}};
    g_src = {6{bar[1]}};
    b_src = {5{bar[0]}};
  end
`else
  always_comb begin
    r_src = red_in;
    g_src = green_in;
    b_src = blue_in;
  end
`endif
  // pixel_en is registered so it stays low in reset even when CLK_DIV is 1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      pixel_en <= 1'b0;
      hc <= '0;
      vc <= '0;
      lcd_de <= 1'b0;
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      lcd_red <= '0;
      lcd_green <= '0;
      lcd_blue <= '0;
    end else begin
      div <= div == D_LAST ? '0 : div + DW'(1);
      pixel_en <= div == D_LAST;
      if (pixel_en) begin
        hc <= h_last ? '0 : hc + HW'(1);
        if (h_last) vc <= v_last ? '0 : vc + VW'(1);
        lcd_de <= vis;
        lcd_hsync <= !h_sync;
        lcd_vsync <= !v_sync;
        lcd_red <= vis ? r_src : '0;
        lcd_green <= vis ? g_src : '0;
        lcd_blue <= vis ? b_src : '0;
      end
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: randomized check of lcd_timing_gen against a pixel-index model on a reduced panel geometry.
module tb_lcd_timing_gen;
  localparam int C = 3, HA = 16, HF = 2, HS = 3, HB = 2, VA = 8, VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef LCD_TEST_PATTERN_EN
  localparam int PIN_K = HT * 3 + 9;
  localparam logic [15:0] PIN_V = 16'hF800;
`else
  localparam int PIN_K = HT * 3 + 5;
  localparam logic [15:0] PIN_V = 16'h207F;
`endif
  logic clock = 1'b0, reset_n;
  logic [4:0] red_in, blue_in, lcd_red, lcd_blue;
  logic [5:0] green_in, lcd_green;
  logic [8:0] x, y;
  logic pixel_en, frame_start, lcd_de, lcd_hsync, lcd_vsync;
  int checks = 0, failures = 0;
  int n = 0, hold = 0, first_pe = -1, period = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, windows = 0;
  bit win_valid = 0, rst1_done = 0;
  logic [15:0] exp_col = '0, pend = '0;

  lcd_timing_gen #(.CLK_DIV(C), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
    .clock(clock), .reset_n(reset_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .x(x), .y(y), .pixel_en(pixel_en), .frame_start(frame_start), .lcd_de(lcd_de),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_red(lcd_red), .lcd_green(lcd_green),
    .lcd_blue(lcd_blue));

  always #5 clock = ~clock;

  // n counts clock edges since reset release; pixel k is on screen after edge n
  function automatic int kof(int e);
    return e < 1 ? 0 : (e - 1) / C;
  endfunction
  function automatic bit pe(int e);
    return e >= 1 && e % C == 0;
  endfunction
  function automatic bit visible(int k);
    return k % HT < HA && (k / HT) % VT < VA;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int k, hp, vp, php, pvp;
    k = kof(n);
    hp = k % HT;
    vp = (k / HT) % VT;
    php = (k + HT - 1) % HT;
    pvp = ((k + HT * VT - 1) / HT) % VT;
    chk("x", int'(x), hp < HA ? hp : 0);
    chk("y", int'(y), vp < VA ? vp : 0);
    chk("pixel_en", int'(pixel_en), int'(pe(n)));
    chk("frame_start", int'(frame_start), int'(pe(n) && k % (HT * VT) == HT * VT - 1));
    chk("lcd_de", int'(lcd_de), int'(k > 0 && visible(k - 1)));
    chk("lcd_hsync", int'(lcd_hsync), int'(k == 0 || php < HA + HF || php >= HA + HF + HS));
    chk("lcd_vsync", int'(lcd_vsync), int'(k == 0 || pvp < VA + VF || pvp >= VA + VF + VS));
    chk("rgb", int'({lcd_red, lcd_green, lcd_blue}), int'(exp_col));
  endtask

  task automatic drive(input bit masked);
    int k, hp, vp;
    logic [15:0] v, m;
    logic [8:0] xx, yy;
    logic [2:0] bar;
    k = kof(n);
    hp = k % HT;
    vp = (k / HT) % VT;
    xx = 9'(hp < HA ? hp : 0);
    yy = 9'(vp < VA ? vp : 0);
    m = masked ? 16'($urandom) : 16'h0;
    if (reset_n && pe(n)) begin
      v = {xx[4:0], yy[5:0], 5'h1F} ^ m;
      {red_in, green_in, blue_in} = v;
`ifdef LCD_TEST_PATTERN_EN
      bar = 3'(hp * 8 / HA);
      v = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
`else
      bar = 3'd0;
`endif
      pend = visible(k) ? v : 16'h0;
    end else begin
      {red_in, green_in, blue_in} = 16'($urandom);
    end
  endtask

  task automatic windows_and_pins(input int c);
    if (reset_n) begin
      period++;
      if (lcd_de) de_cnt++;
      if (!lcd_hsync) hs_cnt++;
      if (!lcd_vsync) vs_cnt++;
      if (pixel_en && first_pe < 0) first_pe = n;
      if (n == 10) chk("first_pixel_en_clock", first_pe, 3);
      if (c < 1500 && n % C == 1 && kof(n) == PIN_K) chk("rgb_pin", int'({lcd_red, lcd_green, lcd_blue}), int'(PIN_V));
      if (frame_start) begin
        if (win_valid) begin
          chk("frame_clocks", period, 897);
          chk("de_clocks", de_cnt, 384);
          chk("hsync_low_clocks", hs_cnt, 117);
          chk("vsync_low_clocks", vs_cnt, 138);
          windows++;
        end
        win_valid = 1;
        {period, de_cnt, hs_cnt, vs_cnt} = '0;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    {red_in, green_in, blue_in} = '0;
    repeat (3) begin
      @(posedge clock);
      #1 check_all();
    end
    hold = 1;
    for (int c = 0; c < 7000; c++) begin
      @(negedge clock);
      if (hold > 0) begin
        hold--;
        if (hold == 0) reset_n = 1'b1;
      end
      drive(c > 1500);
      @(posedge clock);
      if (reset_n) begin
        if (pe(n)) exp_col = pend;
        n++;
      end
      #1 check_all();
      windows_and_pins(c);
      if (reset_n && hold == 0 && ((c > 2000 && !rst1_done && kof(n) % HT == 10 && (kof(n) / HT) % VT == 5)
          || c == 4000 + int'($urandom_range(0, 500)) % 500)) begin
        rst1_done = 1;
        #1 reset_n = 1'b0;
        n = 0;
        exp_col = '0;
        win_valid = 0;
        first_pe = -1;
        #1 check_all();
        hold = 2;
      end
    end
    chk("frame_windows_seen", int'(windows >= 4), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
